timer_entry_ctrl: RTL
=====================

// Module: timer_entry_ctrl
// PURPOSE
//  Parametrised keypad timer-entry controller for the microwave. Decodes 10 digit
//  switches and shifts debounced presses into an N-digit BCD MM..M:SS register.
//  Validates the entry and issues a one-cycle active-low load strobe to the
//  downstream down-counter. Generates that counter's 1 Hz tick while cooking.
//  Sits between the keypad switches and the timer down-counter/display.
// PARAMETERS
//  NUM_DIGITS       4    BCD digits held; digit0 = units of seconds; minimum 3
//  CLK_FREQ_HZ      100  clk cycles per tick_1hz pulse; minimum 2
//  DEBOUNCE_CYCLES  2    consecutive identical samples needed to accept a code; minimum 1
// PORTS
//  clk         in   1             system clock; all logic on rising edge
//  rstn        in   1             asynchronous active-low reset
//  switches    in   10            digit keys; bit k = key k, highest set bit wins
//  clear       in   1             synchronous clear of the entry, level-sampled
//  start       in   1             request load and run, level-sampled
//  done        in   1             down-counter reached zero
//  digits      out  4*NUM_DIGITS  BCD entry, digit i at [4i+3:4i]
//  entry_count out  clog2(N+1)    digits entered, saturates at NUM_DIGITS
//  loadn       out  1             active-low load strobe, low exactly 1 cycle
//  tick_1hz    out  1             1-cycle pulse every CLK_FREQ_HZ cycles in RUN
//  running     out  1             high in RUN state
//  err         out  1             1-cycle pulse when start is rejected
// BEHAVIOUR
//  Reset (rstn=0, async): digits=0, entry_count=0, loadn=1, tick_1hz=0,
//   running=0, err=0, state=EMPTY, last code=NONE, divider=0.
//  Key decode: code = highest set switch index, or NONE if all zero. Debounce:
//   code must match for DEBOUNCE_CYCLES consecutive cycles before it becomes
//   stable_code. A press is accepted on the cycle stable_code changes to a value
//   other than NONE. Holding a key gives no repeat. Key A to key B without
//   release gives a new press once B is stable.
//  Accepted press (EMPTY or ENTRY): digits <= {digits[4N-5:0], code}. The top
//   digit is discarded. entry_count+1, saturating. State goes to ENTRY.
//  FSM: EMPTY -> ENTRY on press. ENTRY -> LOAD on start when entry_count>0 and
//   the entry is valid. LOAD -> RUN after 1 cycle, with loadn=0 in LOAD only.
//   RUN -> EMPTY on done or clear. Presses and start are ignored in LOAD and RUN,
//   but last code still tracks, so a key held across RUN->EMPTY is not accepted.
//  Valid: digit1 <= 5. On an invalid start, err=1 for 1 cycle, the state stays
//   ENTRY, and digits are unchanged.
//  start in EMPTY is ignored, with no err. done outside RUN is ignored.
//  Priority in one cycle: clear > start > press. Clear zeroes digits and
//   entry_count, goes to EMPTY, and discards any same-cycle press.
//  Divider: cleared on entry to RUN. tick_1hz is first asserted CLK_FREQ_HZ
//   cycles after the LOAD cycle, then every CLK_FREQ_HZ cycles. It is forced
//   low and the divider cleared outside RUN.
//  digits are held constant in LOAD and RUN. The downstream counter owns the
//   countdown.
// CONFIGURATION
//  SECONDS_NORMALISE_EN defined: start with digit1 > 5 is accepted, not
//   rejected. In the LOAD cycle, seconds S = 10*d1 + d0 becomes S - 60 and
//   minutes (digits N-1..2) are BCD-incremented with ripple carry. If minutes
//   are already all 9, the result saturates to minutes all 9 and seconds 59.
//   digits are valid with loadn=0, and err is never asserted.
//  Undefined: the validity rule above applies and no normalisation logic exists.
// TESTING
//  1. Keys 1,3,0 held 3 cycles each with release -> digits=0x0130, entry_count=3.
//     start -> loadn=0 one cycle, running=1.
//  2. Key 5 held 20 cycles -> one accepted digit only. Key 5 then 7 with no
//     release -> digits=0x0057.
//  3. Five presses 1..5, N=4 -> digits=0x2345, entry_count=4.
//     clear+start same cycle -> digits=0, EMPTY, loadn stays 1.
//  4. RUN, CLK_FREQ_HZ=100 -> tick_1hz at cycles 100, 200 after LOAD.
//     done -> running=0, tick_1hz=0, EMPTY.
//  5. Entry 0x0090 with macro undefined, start -> err pulse, ENTRY, no loadn.
//     With SECONDS_NORMALISE_EN -> loaded digits=0x0130.
//     With SECONDS_NORMALISE_EN, 0x9990 -> 0x9959.
//  6. rstn pulsed low mid-RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/timer_entry_ctrl.sv
// Keypad timer-entry controller: debounced BCD digit entry, validated load strobe, 1 Hz run tick.
// Optional feature macro: SECONDS_NORMALISE_EN (seconds >= 60 folded into minutes at load).
module timer_entry_ctrl #(
  parameter int NUM_DIGITS      = 4,
  parameter int CLK_FREQ_HZ     = 100,
  parameter int DEBOUNCE_CYCLES = 2,
  localparam int CW             = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [9:0]              switches,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    done,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [CW-1:0]           entry_count,
  output logic                    loadn,
  output logic                    tick_1hz,
  output logic                    running,
  output logic                    err
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int VW = $clog2(CLK_FREQ_HZ);
  localparam logic [3:0]    NONE   = 4'hF;
  localparam logic [DW-1:0] DB_LEN = DW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_DIGITS);
  localparam logic [VW-1:0] DIV_MAX = VW'(CLK_FREQ_HZ - 1);

  typedef enum logic [1:0] {S_EMPTY, S_ENTRY, S_LOAD, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0]              raw_q, raw_d, stable_q, stable_d, code;
  logic [DW-1:0]           run_q, run_d;
  logic [VW-1:0]           div_q, div_d;
  logic                    err_q, err_d;
  logic                    press, start_ok;

`ifdef SECONDS_NORMALISE_EN
  // Fold seconds 60..99 into one extra minute; an all-9 minute field pins at 9..9:59.
  function automatic logic [4*NUM_DIGITS-1:0] normalise(input logic [4*NUM_DIGITS-1:0] v);
    logic [4*NUM_DIGITS-1:0] r;
    logic all9, carry;
    r     = v;
    all9  = 1'b1;
    carry = 1'b1;
    for (int i = 2; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] != 4'd9) all9 = 1'b0;
    if (v[7:4] > 4'd5) begin
      if (all9) begin
        r[7:0] = 8'h59;
      end else begin
        r[7:4] = v[7:4] - 4'd6;
        for (int i = 2; i < NUM_DIGITS; i++) begin
          if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
              r[4*i +: 4] = 4'd0;
            end else begin
              r[4*i +: 4] = r[4*i +: 4] + 4'd1;
              carry       = 1'b0;
            end
          end
        end
      end
    end
    return r;
  endfunction
  assign start_ok = 1'b1;
`else
  assign start_ok = (digits_q[7:4] <= 4'd5);
`endif

  always_comb begin
    code = NONE;
    for (int k = 0; k < 10; k++)
      if (switches[k]) code = 4'(k);
  end

  // Debounce keeps running in every state so a key held through RUN is never re-accepted.
  always_comb begin
    raw_d = code;
    if (code == raw_q) run_d = (run_q >= DB_LEN) ? run_q : run_q + 1'b1;
    else               run_d = DW'(1);
    stable_d = (run_d >= DB_LEN) ? code : stable_q;
    press    = (stable_d != stable_q) && (stable_d != NONE);
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    if (clear) begin
      state_d  = S_EMPTY;
      digits_d = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        S_EMPTY, S_ENTRY: begin
          if (state_q == S_ENTRY && start) begin
            if (start_ok) begin
              state_d = S_LOAD;
`ifdef SECONDS_NORMALISE_EN
              digits_d = normalise(digits_q);
`endif
            end else begin
              err_d = 1'b1;
            end
          end else if (press) begin
            state_d  = S_ENTRY;
            digits_d = {digits_q[4*NUM_DIGITS-5:0], stable_d};
            cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end
        end
        S_LOAD:  state_d = S_RUN;
        S_RUN:   if (done) state_d = S_EMPTY;
        default: state_d = S_EMPTY;
      endcase
    end
    if (state_q == S_RUN && state_d == S_RUN) div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
    else                                      div_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_EMPTY;
      digits_q <= '0;
      cnt_q    <= '0;
      raw_q    <= NONE;
      run_q    <= '0;
      stable_q <= NONE;
      div_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      raw_q    <= raw_d;
      run_q    <= run_d;
      stable_q <= stable_d;
      div_q    <= div_d;
      err_q    <= err_d;
    end
  end

  assign digits      = digits_q;
  assign entry_count = cnt_q;
  assign loadn       = (state_q != S_LOAD);
  assign running     = (state_q == S_RUN);
  assign tick_1hz    = (state_q == S_RUN) && (div_q == DIV_MAX);
  assign err         = err_q;
endmodule
